// File: rtl/clk_meter_pkg.sv
// Shared definitions for the clock period meter: FSM state encoding and
// default sizing constants.
package clk_meter_pkg;

    // Default counter width and lost-signal threshold.
    localparam int unsigned DEF_CNT_W       = 32;
    localparam int unsigned DEF_TIMEOUT     = 1000000;
    localparam int unsigned DEF_SYNC_STAGES = 2;

    // Measurement FSM states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_MEAS = 2'd2
    } meter_state_t;

endpackage

// File: rtl/sync_edge_det.sv
// Brings an asynchronous input into the clk domain through a flop chain
// and derives single-cycle rise/fall pulses from the synchronized level.
// Reusable for any asynchronous single-bit input.
module sync_edge_det
    import clk_meter_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic clk,
    input  logic reset_n,
    input  logic async_in,
    output logic sync_level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;

    // Synchronizer chain followed by one history flop for edge detection.
    // NOTE: the synchronizer flops are reset too, so a stale level cannot
    // produce a phantom edge right after reset is released.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbour.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
            hist_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
            hist_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign sync_level = sync_q[SYNC_STAGES-1];
    assign rise       = sync_level & ~hist_q;
    assign fall       = ~sync_level & hist_q;

endmodule

// File: rtl/clk_period_meter.sv
// Measures period and high time of an asynchronous slow signal in clk
// cycles, and flags a lost signal after TIMEOUT cycles without a rising
// edge. Optional feature macro PERIOD_METER_MINMAX_EN adds running
// minimum/maximum period tracking with a clear input.
module clk_period_meter
    import clk_meter_pkg::*;
#(
    parameter int unsigned CNT_W       = DEF_CNT_W,
    parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int unsigned TIMEOUT     = DEF_TIMEOUT
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             sig_in,
    input  logic             enable,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             meas_valid,
    output logic             locked,
    output logic             timeout
`ifdef PERIOD_METER_MINMAX_EN
    ,
    input  logic             minmax_clr,
    output logic [CNT_W-1:0] period_min,
    output logic [CNT_W-1:0] period_max
`endif
);

    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    logic rise;
    logic fall;
    logic sig_sync_unused;

    meter_state_t     state_q,   state_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;
    logic [CNT_W-1:0] cnt_inc;
    logic [CNT_W-1:0] period_q,  period_d;
    logic [CNT_W-1:0] high_q,    high_d;
    logic [CNT_W-1:0] shadow_q,  shadow_d;
    logic             mv_q,      mv_d;
    logic             locked_q,  locked_d;
    logic             timeout_q, timeout_d;

    sync_edge_det #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk        (clk),
        .reset_n    (reset_n),
        .async_in   (sig_in),
        .sync_level (sig_sync_unused),
        .rise       (rise),
        .fall       (fall)
    );

    // Counter advances but sticks at all-ones instead of wrapping.
    assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CNT_ONE;

    // State and measurement registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            period_q  <= '0;
            high_q    <= '0;
            shadow_q  <= '0;
            mv_q      <= 1'b0;
            locked_q  <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            period_q  <= period_d;
            high_q    <= high_d;
            shadow_q  <= shadow_d;
            mv_q      <= mv_d;
            locked_q  <= locked_d;
            timeout_q <= timeout_d;
        end
    end

    // Next-state and next-value logic; disable overrides everything,
    // so an edge coinciding with enable dropping never reports.
    always_comb begin
        // NOTE: every variable gets a hold/default value first so no path
        // through the case leaves it unassigned and infers a latch.
        state_d   = state_q;
        cnt_d     = cnt_q;
        period_d  = period_q;
        high_d    = high_q;
        shadow_d  = shadow_q;
        mv_d      = 1'b0;
        locked_d  = locked_q;
        timeout_d = timeout_q;

        if (!enable) begin
            state_d   = ST_IDLE;
            cnt_d     = '0;
            locked_d  = 1'b0;
            timeout_d = 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    state_d   = ST_WAIT;
                    cnt_d     = '0;
                    locked_d  = 1'b0;
                    timeout_d = 1'b0;
                end
                ST_WAIT: begin
                    // First edge only arms the period counter.
                    if (rise) begin
                        state_d = ST_MEAS;
                        cnt_d   = CNT_ONE;
                    end else if (cnt_q == TIMEOUT_C) begin
                        timeout_d = 1'b1;
                        cnt_d     = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                ST_MEAS: begin
                    cnt_d = cnt_inc;
                    if (fall) begin
                        shadow_d = cnt_q;
                    end
                    if (rise) begin
                        period_d  = cnt_q;
                        high_d    = shadow_q;
                        cnt_d     = CNT_ONE;
                        mv_d      = 1'b1;
                        locked_d  = 1'b1;
                        timeout_d = 1'b0;
                    end else if (cnt_q == TIMEOUT_C) begin
                        timeout_d = 1'b1;
                        locked_d  = 1'b0;
                        cnt_d     = '0;
                        state_d   = ST_WAIT;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    assign period     = period_q;
    assign high_time  = high_q;
    assign meas_valid = mv_q;
    assign locked     = locked_q;
    assign timeout    = timeout_q;

`ifdef PERIOD_METER_MINMAX_EN
    logic [CNT_W-1:0] min_q;
    logic [CNT_W-1:0] max_q;

    // Running extremes of the reported period; clear beats a new sample.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            min_q <= '1;
            max_q <= '0;
        end else if (minmax_clr) begin
            min_q <= '1;
            max_q <= '0;
        end else if (mv_q) begin
            if (period_q < min_q) min_q <= period_q;
            if (period_q > max_q) max_q <= period_q;
        end
    end

    assign period_min = min_q;
    assign period_max = max_q;
`endif

endmodule

// File: tb/tb_clk_period_meter.sv
// Self-checking bench for clk_period_meter: table of waveform shapes with
// a scoreboard queue of expected measurements, plus hand-written sequences
// for timeout, enable drop, async reset and (if PERIOD_METER_MINMAX_EN is
// defined) min/max tracking.
module tb_clk_period_meter;

    localparam int unsigned CNT_W      = 32;
    localparam int unsigned TB_TIMEOUT = 100;

    typedef struct {
        int unsigned high;
        int unsigned low;
        int unsigned reps;
        logic [31:0] exp_period;
        logic [31:0] exp_high;
    } vec_t;

    typedef struct {
        logic [31:0] p;
        logic [31:0] h;
    } exp_t;

    logic             clk;
    logic             reset_n;
    logic             sig_in;
    logic             enable;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high_time;
    logic             meas_valid;
    logic             locked;
    logic             timeout;
`ifdef PERIOD_METER_MINMAX_EN
    logic             minmax_clr;
    logic [CNT_W-1:0] period_min;
    logic [CNT_W-1:0] period_max;
`endif

    clk_period_meter #(
        .CNT_W       (CNT_W),
        .SYNC_STAGES (2),
        .TIMEOUT     (TB_TIMEOUT)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .sig_in     (sig_in),
        .enable     (enable),
        .period     (period),
        .high_time  (high_time),
        .meas_valid (meas_valid),
        .locked     (locked),
        .timeout    (timeout)
`ifdef PERIOD_METER_MINMAX_EN
        ,
        .minmax_clr (minmax_clr),
        .period_min (period_min),
        .period_max (period_max)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    int          cyc = 0;
    int          last_mv_cyc = 0;
    int          mv_seen = 0;
    int          n_push = 0;
    logic        prev_mv = 1'b0;
    exp_t        exp_q[$];
    exp_t        mon_e;

    // Driver-side scoreboard state: the shape of the period just started.
    logic        armed = 1'b0;
    logic        prev_valid = 1'b0;
    logic [31:0] prev_p = '0;
    logic [31:0] prev_h = '0;

    vec_t vecs[7];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // A rising edge completes the previous period; queue its expectation.
    task note_rise(input logic [31:0] ep, input logic [31:0] eh);
        if (armed && prev_valid) begin
            exp_q.push_back('{p: prev_p, h: prev_h});
            n_push++;
        end
        prev_valid = armed;
        prev_p     = ep;
        prev_h     = eh;
        sig_in     = 1'b1;
    endtask

    // One full period starting at the current negedge; returns at the
    // negedge where the next rising edge may be driven.
    task drive_period(input int unsigned h, input int unsigned l,
                      input logic [31:0] ep, input logic [31:0] eh);
        note_rise(ep, eh);
        repeat (h) @(negedge clk);
        sig_in = 1'b0;
        repeat (l) @(negedge clk);
    endtask

    always @(posedge clk) cyc++;

    // Monitor: every meas_valid pops one expectation.
    always @(negedge clk) begin
        if (!reset_n) begin
            prev_mv = 1'b0;
        end else begin
            if (meas_valid) begin
                mv_seen++;
                last_mv_cyc = cyc;
                check("mv_back_to_back", prev_mv, 1'b0);
                check("mv_expected", exp_q.size() != 0, 1'b1);
                if (exp_q.size() != 0) begin
                    mon_e = exp_q.pop_front();
                    check("period", period, mon_e.p);
                    check("high_time", high_time, mon_e.h);
                end
                check("locked_on_mv", locked, 1'b1);
                check("timeout_on_mv", timeout, 1'b0);
            end
            prev_mv = meas_valid;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int mv_before;
        int i;

        vecs[0] = '{high: 8,  low: 8,  reps: 4, exp_period: 16, exp_high: 8};
        vecs[1] = '{high: 3,  low: 10, reps: 3, exp_period: 13, exp_high: 3};
        vecs[2] = '{high: 1,  low: 1,  reps: 8, exp_period: 2,  exp_high: 1};
        vecs[3] = '{high: 5,  low: 7,  reps: 3, exp_period: 12, exp_high: 5};
        vecs[4] = '{high: 10, low: 10, reps: 3, exp_period: 20, exp_high: 10};
        vecs[5] = '{high: 2,  low: 1,  reps: 4, exp_period: 3,  exp_high: 2};
        vecs[6] = '{high: 8,  low: 8,  reps: 3, exp_period: 16, exp_high: 8};

        reset_n = 1'b0;
        enable  = 1'b0;
        sig_in  = 1'b0;
`ifdef PERIOD_METER_MINMAX_EN
        minmax_clr = 1'b0;
`endif
        repeat (3) @(negedge clk);
        check("rst_period", period, 0);
        check("rst_high_time", high_time, 0);
        check("rst_meas_valid", meas_valid, 0);
        check("rst_locked", locked, 0);
        check("rst_timeout", timeout, 0);
`ifdef PERIOD_METER_MINMAX_EN
        check("rst_period_min", period_min, 32'hFFFF_FFFF);
        check("rst_period_max", period_max, 0);
`endif
        reset_n = 1'b1;
        @(negedge clk);

        // First rising edge only arms the meter.
        enable = 1'b1;
        armed  = 1'b1;
        drive_period(8, 8, 16, 8);
        check("first_edge_no_mv", mv_seen, 0);
        check("first_edge_unlocked", locked, 0);

        // Table-driven shapes.
        foreach (vecs[k]) begin
            for (int r = 0; r < int'(vecs[k].reps); r++)
                drive_period(vecs[k].high, vecs[k].low, vecs[k].exp_period, vecs[k].exp_high);
        end
        check("locked_after_table", locked, 1);

        // Signal stuck low: timeout exactly TIMEOUT cycles after last counted edge.
        prev_valid = 1'b0;
        for (i = 0; i < 400 && !timeout; i++) @(negedge clk);
        check("timeout_set", timeout, 1);
        check("timeout_delay", cyc - last_mv_cyc, TB_TIMEOUT);
        check("timeout_unlocked", locked, 0);
        check("timeout_period_hold", period, 16);

        // Restart: timeout clears only on the first measurement after two rises.
        mv_before = mv_seen;
        drive_period(8, 8, 16, 8);
        check("restart_timeout_held", timeout, 1);
        check("restart_one_rise_no_mv", mv_seen, mv_before);
        drive_period(8, 8, 16, 8);
        drive_period(8, 8, 16, 8);
        check("restart_timeout_clear", timeout, 0);
        check("restart_locked", locked, 1);

        // Drop enable in the middle of a high phase.
        note_rise(16, 8);
        repeat (5) @(negedge clk);
        mv_before  = mv_seen;
        enable     = 1'b0;
        armed      = 1'b0;
        prev_valid = 1'b0;
        @(negedge clk);
        check("dis_locked", locked, 0);
        check("dis_meas_valid", meas_valid, 0);
        check("dis_period_hold", period, 16);
        repeat (2) @(negedge clk);
        sig_in = 1'b0;
        repeat (8) @(negedge clk);
        drive_period(4, 4, 8, 4);
        drive_period(4, 4, 8, 4);
        check("dis_no_mv", mv_seen, mv_before);
        check("dis_period_still", period, 16);
        check("dis_high_still", high_time, 8);

        // Re-enable: two rises before the first valid measurement.
        enable = 1'b1;
        armed  = 1'b1;
        drive_period(5, 7, 12, 5);
        check("reen_one_rise_no_mv", mv_seen, mv_before);
        drive_period(5, 7, 12, 5);
        drive_period(5, 7, 12, 5);
        check("reen_period", period, 12);

        // Asynchronous reset in the middle of a measurement.
        note_rise(12, 5);
        repeat (6) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("arst_period", period, 0);
        check("arst_high_time", high_time, 0);
        check("arst_meas_valid", meas_valid, 0);
        check("arst_locked", locked, 0);
        check("arst_timeout", timeout, 0);
        check("arst_queue_empty", exp_q.size(), 0);
        prev_valid = 1'b0;
        @(negedge clk);
        sig_in = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // Power-on behaviour again: periods 12, 20, 16 get measured.
        mv_before = mv_seen;
        drive_period(5, 7, 12, 5);
        check("post_rst_no_mv", mv_seen, mv_before);
        drive_period(10, 10, 20, 10);
        drive_period(8, 8, 16, 8);
        drive_period(8, 8, 16, 8);
        repeat (4) @(negedge clk);
        check("post_rst_period", period, 16);
        check("post_rst_high", high_time, 8);
        check("post_rst_mv_count", mv_seen - mv_before, 3);
`ifdef PERIOD_METER_MINMAX_EN
        check("minmax_min", period_min, 12);
        check("minmax_max", period_max, 20);
        minmax_clr = 1'b1;
        @(negedge clk);
        minmax_clr = 1'b0;
        check("minmax_clr_min", period_min, 32'hFFFF_FFFF);
        check("minmax_clr_max", period_max, 0);
`endif

        repeat (20) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        check("mv_total", mv_seen, n_push);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
